systolic_array_top: RTL and testbench

- Output-stationary systolic matrix multiplier: computes C = A x B, with A of size array_height_p x K, B of size K x array_width_p, and K set at run time by the number of accepted beats.
- Each input beat carries one column of A and one row of B (one outer-product step).
- After flush, results leave one row of C per beat over a valid/yumi handshake.
- Top level of the systolic-array datapath; sits between a stream producer and a consumer.

---
 rtl/systolic_pkg.sv | 23 ++
 rtl/systolic_array_pe.sv | 44 ++++
 rtl/systolic_array_top.sv | 160 ++++++++++++++++
 tb/tb_systolic_array_top.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the output-stationary systolic multiplier: FSM states,
// the PE link (operand plus valid tag) and the accumulator width rule.
package systolic_pkg;

   typedef enum logic [1:0] {
      LOAD,
      DRAIN,
      OUTPUT
   } state_e;

   // Operands are sign-extended into the link, so width_p may not exceed this.
   localparam int link_data_w_lp = 16;

   typedef struct packed {
      logic                             vld;
      logic signed [link_data_w_lp-1:0] data;
   } pe_link_t;

   function automatic int acc_width(input int width);
      return 2 * width + 8;
   endfunction

endpackage

// File: rtl/systolic_array_pe.sv
// One processing element: registers a (rightward) and b (downward) with
// their tags, and accumulates a*b whenever both incoming tags are set.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int acc_width_p = 24
)
(
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          en_i,
   input  logic                          clear_i,
   input  pe_link_t                      a_i,
   input  pe_link_t                      b_i,
   output pe_link_t                      a_o,
   output pe_link_t                      b_o,
   output logic signed [acc_width_p-1:0] acc_o
);

   logic signed [2*link_data_w_lp-1:0] prod_p0;
   logic signed [acc_width_p-1:0]      prod_ext_p0;

   always_comb begin
      prod_p0     = $signed(a_i.data) * $signed(b_i.data);
      prod_ext_p0 = acc_width_p'(prod_p0);
   end

   // stage p0 -> p1: forward operands, accumulate modulo 2^acc_width_p
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         a_o   <= '0;
         b_o   <= '0;
         acc_o <= '0;
      end else if (en_i) begin
         a_o <= a_i;
         b_o <= b_i;
         if (clear_i)
            acc_o <= '0;
         else if (a_i.vld && b_i.vld)
            acc_o <= acc_o + prod_ext_p0;
      end
   end

endmodule

// File: rtl/systolic_array_top.sv
// Output-stationary systolic C = A x B: skewed operand injection, PE grid,
// and a LOAD/DRAIN/OUTPUT controller streaming one C row per handshake.
module systolic_array_top
   import systolic_pkg::*;
#(
   parameter int width_p        = 8,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2
)
(
   input  logic                                            clk_i,
   input  logic                                            reset_i,
   input  logic                                            en_i,
   input  logic                                            flush_i,
   output logic                                            ready_o,
   input  logic                                            valid_i,
   input  logic [(array_height_p+array_width_p)*width_p-1:0] data_i,
   output logic                                            valid_o,
   input  logic                                            yumi_i,
   output logic [array_width_p*acc_width(width_p)-1:0]     data_o
);

   localparam int acc_width_lp    = acc_width(width_p);
   localparam int drain_cycles_lp = array_height_p + array_width_p;
   localparam int cnt_w_lp        = $clog2(drain_cycles_lp);
   localparam int row_w_lp        = (array_height_p > 1) ? $clog2(array_height_p) : 1;

   state_e                state_q, state_n;
   logic [cnt_w_lp-1:0]   cnt_q, cnt_n;
   logic [row_w_lp-1:0]   row_q, row_n;
   logic                  clear_acc;
   logic                  accept;

   pe_link_t a_link [array_height_p][array_width_p+1];
   pe_link_t b_link [array_height_p+1][array_width_p];
   pe_link_t a_edge_unused [array_height_p];
   pe_link_t b_edge_unused [array_width_p];
   logic signed [acc_width_lp-1:0] acc [array_height_p][array_width_p];

   assign ready_o = en_i & ~reset_i & (state_q == LOAD);
   assign valid_o = en_i & ~reset_i & (state_q == OUTPUT);
   assign accept  = valid_i & ready_o;

   always_comb begin
      state_n   = state_q;
      cnt_n     = cnt_q;
      row_n     = row_q;
      clear_acc = 1'b0;
      case (state_q)
         LOAD: begin
            if (flush_i) begin
               state_n = DRAIN;
               cnt_n   = '0;
            end
         end
         DRAIN: begin
            // Long enough for the last skewed beat to reach PE(h-1,w-1).
            if (cnt_q == cnt_w_lp'(drain_cycles_lp - 1)) begin
               state_n = OUTPUT;
               row_n   = '0;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         OUTPUT: begin
            if (yumi_i) begin
               if (row_q == row_w_lp'(array_height_p - 1)) begin
                  state_n   = LOAD;
                  row_n     = '0;
                  clear_acc = 1'b1;
               end else begin
                  row_n = row_q + 1'b1;
               end
            end
         end
         default: state_n = LOAD;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         row_q   <= '0;
      end else if (en_i) begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         row_q   <= row_n;
      end
   end

   // stage p0: A element i enters row i after i cycles of skew
   for (genvar i = 0; i < array_height_p; i++) begin : g_a_skew
      pe_link_t a_in_p0;
      assign a_in_p0 = '{vld: accept,
                         data: link_data_w_lp'($signed(data_i[i*width_p +: width_p]))};
      if (i == 0) begin : g_direct
         assign a_link[i][0] = a_in_p0;
      end else begin : g_delay
         pe_link_t skew_p1 [i];
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               for (int k = 0; k < i; k++) skew_p1[k] <= '0;
            end else if (en_i) begin
               skew_p1[0] <= a_in_p0;
               for (int k = 1; k < i; k++) skew_p1[k] <= skew_p1[k-1];
            end
         end
         assign a_link[i][0] = skew_p1[i-1];
      end
      assign a_edge_unused[i] = a_link[i][array_width_p];
   end

   // stage p0: B element j enters column j after j cycles of skew
   for (genvar j = 0; j < array_width_p; j++) begin : g_b_skew
      pe_link_t b_in_p0;
      assign b_in_p0 = '{vld: accept,
                         data: link_data_w_lp'($signed(data_i[(array_height_p+j)*width_p +: width_p]))};
      if (j == 0) begin : g_direct
         assign b_link[0][j] = b_in_p0;
      end else begin : g_delay
         pe_link_t skew_p1 [j];
         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               for (int k = 0; k < j; k++) skew_p1[k] <= '0;
            end else if (en_i) begin
               skew_p1[0] <= b_in_p0;
               for (int k = 1; k < j; k++) skew_p1[k] <= skew_p1[k-1];
            end
         end
         assign b_link[0][j] = skew_p1[j-1];
      end
      assign b_edge_unused[j] = b_link[array_height_p][j];
   end

   for (genvar i = 0; i < array_height_p; i++) begin : g_row
      for (genvar j = 0; j < array_width_p; j++) begin : g_col
         systolic_pe #(
            .acc_width_p (acc_width_lp)
         ) u_pe (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (en_i),
            .clear_i (clear_acc),
            .a_i     (a_link[i][j]),
            .b_i     (b_link[i][j]),
            .a_o     (a_link[i][j+1]),
            .b_o     (b_link[i+1][j]),
            .acc_o   (acc[i][j])
         );
      end
   end

   always_comb begin
      data_o = '0;
      for (int j = 0; j < array_width_p; j++)
         data_o[j*acc_width_lp +: acc_width_lp] = acc[row_q][j];
   end

endmodule

// File: tb/tb_systolic_array_top.sv
// Bench for systolic_array_top: directed and random matrix products checked
// against a plain triple-loop matrix multiply.
module tb_systolic_array_top;

   localparam int W    = 8;
   localparam int AW   = 2;
   localparam int AH   = 2;
   localparam int ACC  = 2*W + 8;
   localparam int MAXK = 16;

   logic                 clk = 1'b0;
   logic                 reset_i, en_i, flush_i, valid_i, yumi_i;
   logic [(AH+AW)*W-1:0] data_i;
   logic                 ready_o, valid_o;
   logic [AW*ACC-1:0]    data_o;

   int checks   = 0;
   int failures = 0;

   int am [AH][MAXK];
   int bm [MAXK][AW];

   always #5 clk = ~clk;

   systolic_array_top #(
      .width_p        (W),
      .array_width_p  (AW),
      .array_height_p (AH)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .en_i    (en_i),
      .flush_i (flush_i),
      .ready_o (ready_o),
      .valid_i (valid_i),
      .data_i  (data_i),
      .valid_o (valid_o),
      .yumi_i  (yumi_i),
      .data_o  (data_o)
   );

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ACC-1:0] ref_c(input int r, input int c, input int k_n);
      longint s;
      s = 0;
      for (int k = 0; k < k_n; k++)
         s += longint'(am[r][k]) * longint'(bm[k][c]);
      return ACC'(s);
   endfunction

   function automatic int rand_elem();
      int v;
      case ($urandom_range(0, 5))
         0:       v = -128;
         1:       v = 127;
         default: v = int'($urandom_range(0, 255)) - 128;
      endcase
      return v;
   endfunction

   task automatic fill_random(input int k_n);
      for (int k = 0; k < k_n; k++) begin
         for (int i = 0; i < AH; i++) am[i][k] = rand_elem();
         for (int j = 0; j < AW; j++) bm[k][j] = rand_elem();
      end
   endtask

   task automatic drive_beat(input int k, input bit flush);
      logic [(AH+AW)*W-1:0] beat;
      beat = '0;
      for (int i = 0; i < AH; i++) beat[i*W +: W] = W'(am[i][k]);
      for (int j = 0; j < AW; j++) beat[(AH+j)*W +: W] = W'(bm[k][j]);
      data_i  = beat;
      valid_i = 1'b1;
      flush_i = flush;
   endtask

   task automatic run_mm(input string name, input int k_n, input int bp, input bit stall);
      int n;
      en_i   = 1'b1;
      yumi_i = 1'b0;
      if (k_n == 0) begin
         valid_i = 1'b0;
         flush_i = 1'b1;
         data_i  = $urandom;
         #1;
         chk({name, ".ready_load"}, ready_o, 1);
         tick();
      end else begin
         for (int k = 0; k < k_n; k++) begin
            drive_beat(k, k == k_n - 1);
            #1;
            chk({name, ".ready_load"}, ready_o, 1);
            tick();
         end
      end
      n = 0;
      while (n < 100) begin
         en_i    = !(stall && n >= 1 && n <= 3);
         valid_i = 1'($urandom_range(0, 1));
         flush_i = 1'($urandom_range(0, 1));
         data_i  = $urandom;
         #1;
         if (valid_o) break;
         chk({name, ".ready_drain"}, ready_o, 0);
         tick();
         n++;
      end
      chk({name, ".latency"}, n, AH + AW + (stall ? 3 : 0));
      en_i = 1'b1;
      for (int r = 0; r < AH; r++) begin
         if (r == 0) begin
            for (int b = 0; b < bp; b++) begin
               yumi_i = 1'b0;
               #1;
               chk({name, ".bp_valid"}, valid_o, 1);
               chk({name, ".bp_ready"}, ready_o, 0);
               for (int j = 0; j < AW; j++)
                  chk({name, ".bp_hold"}, data_o[j*ACC +: ACC], ref_c(0, j, k_n));
               tick();
            end
         end
         yumi_i  = 1'b1;
         valid_i = 1'($urandom_range(0, 1));
         flush_i = 1'($urandom_range(0, 1));
         #1;
         chk({name, ".valid"}, valid_o, 1);
         for (int j = 0; j < AW; j++)
            chk({name, ".c_elem"}, data_o[j*ACC +: ACC], ref_c(r, j, k_n));
         tick();
      end
      yumi_i  = 1'b0;
      valid_i = 1'b0;
      flush_i = 1'b0;
      #1;
      chk({name, ".done_valid"}, valid_o, 0);
      chk({name, ".done_ready"}, ready_o, 1);
   endtask

   initial begin
      reset_i = 1'b1;
      en_i    = 1'b1;
      valid_i = 1'b1;
      flush_i = 1'b1;
      yumi_i  = 1'b0;
      data_i  = '1;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("reset.ready", ready_o, 0);
         chk("reset.valid", valid_o, 0);
      end
      reset_i = 1'b0;
      valid_i = 1'b0;
      flush_i = 1'b0;
      #1;
      chk("release.ready", ready_o, 1);
      chk("release.valid", valid_o, 0);

      am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
      bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
      run_mm("mm2x2", 2, 0, 1'b0);

      am[0][0] = -1; am[0][1] = 0;    am[1][0] = 0; am[1][1] = -128;
      bm[0][0] = 127; bm[0][1] = 1;   bm[1][0] = 0; bm[1][1] = -128;
      run_mm("signed", 2, 0, 1'b0);

      am[0][0] = 1; am[0][1] = 2; am[1][0] = 3; am[1][1] = 4;
      bm[0][0] = 5; bm[0][1] = 6; bm[1][0] = 7; bm[1][1] = 8;
      run_mm("backpressure", 2, 5, 1'b0);

      fill_random(5);
      run_mm("en_stall", 5, 0, 1'b1);

      run_mm("empty", 0, 0, 1'b0);
      fill_random(3);
      run_mm("after_empty", 3, 0, 1'b0);

      // abandon a half-loaded product with reset, then multiply afresh
      fill_random(4);
      drive_beat(0, 1'b0);
      tick();
      drive_beat(1, 1'b0);
      tick();
      reset_i = 1'b1;
      valid_i = 1'b0;
      tick();
      chk("midreset.ready", ready_o, 0);
      tick();
      reset_i = 1'b0;
      fill_random(4);
      run_mm("after_reset", 4, 0, 1'b0);

      for (int t = 0; t < 4; t++) begin
         int k_n;
         k_n = int'($urandom_range(1, MAXK));
         fill_random(k_n);
         run_mm("random", k_n, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
